// File: rtl/timer_sequencer_if.sv
// timer_sequencer_if: requester, timer and status signals of the timer command sequencer.
// Master is the surrounding control logic and timer; slave is the sequencer itself.
interface timer_sequencer_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;
   logic          req_valid;
   logic [3:0]    req_val;
   logic          req_ready;
   logic          hold;
   logic          tmr_start;
   logic [3:0]    tmr_load_val;
   logic          tmr_done;
   logic          cmp_pulse;
   logic [3:0]    cmp_val;
   logic [LW-1:0] level;
   logic          busy;
   logic          err;
   modport master (
      output req_valid, req_val, hold, tmr_done,
      input  req_ready, tmr_start, tmr_load_val, cmp_pulse, cmp_val, level, busy, err
   );
   modport slave (
      input  req_valid, req_val, hold, tmr_done,
      output req_ready, tmr_start, tmr_load_val, cmp_pulse, cmp_val, level, busy, err
   );
endinterface

// File: rtl/timer_sequencer.sv
// timer_sequencer: FIFO of 4-bit load values issued one at a time to the countdown timer.
// Defining TSEQ_WDOG_EN adds a WAIT watchdog that sets a sticky err and abandons the command.
module timer_sequencer #(
   parameter int DEPTH    = 4,
   parameter int WDOG_CYC = 20
) (
   input logic              clk,
   input logic              rst,
   timer_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   typedef enum logic {IDLE, WAIT} state_t;
   state_t        r_state, w_next;
   logic [3:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [LW-1:0] r_level;
   logic [3:0]    r_inflight, r_cmp_val;
   logic          r_cmp_pulse;
   logic          w_full, w_push, w_issue, w_done, w_timeout;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) $error("DEPTH must be a power of two, at least 2");
   if (WDOG_CYC < 18) $error("WDOG_CYC must cover the longest timer run");

   assign w_full = r_level == LW'(DEPTH);
   assign w_push = bus.req_valid && !w_full;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;

   always_comb begin
      w_issue = (r_state == IDLE) && (r_level != '0) && !bus.hold;
      w_done  = (r_state == WAIT) && bus.tmr_done;
      w_next  = w_issue ? WAIT : (w_done || w_timeout) ? IDLE : r_state;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_inflight  <= '0;
         r_cmp_pulse <= 1'b0;
         r_cmp_val   <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= bus.req_val;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_issue) begin
            r_rd_ptr   <= r_rd_ptr + AW'(1);
            r_inflight <= r_mem[r_rd_ptr];
         end
         r_level     <= r_level + LW'(w_push) - LW'(w_issue);
         r_cmp_pulse <= w_done;
         if (w_done) r_cmp_val <= r_inflight;
      end

`ifdef TSEQ_WDOG_EN
   localparam int CW = $clog2(WDOG_CYC);
   logic [CW-1:0] r_wcnt;
   logic          r_err;
   // a done arriving on the last allowed cycle still wins over the timeout
   assign w_timeout = (r_state == WAIT) && !bus.tmr_done && (r_wcnt == CW'(WDOG_CYC - 1));

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_wcnt <= '0;
         r_err  <= 1'b0;
      end else begin
         r_wcnt <= w_issue ? '0 : (r_state == WAIT) ? r_wcnt + CW'(1) : r_wcnt;
         r_err  <= r_err | w_timeout;
      end

   assign bus.err = r_err;
`else
   assign w_timeout = 1'b0;
   assign bus.err   = 1'b0;
`endif

   assign bus.req_ready    = !w_full;
   assign bus.tmr_start    = w_issue;
   assign bus.tmr_load_val = r_mem[r_rd_ptr];
   assign bus.cmp_pulse    = r_cmp_pulse;
   assign bus.cmp_val      = r_cmp_val;
   assign bus.level        = r_level;
   assign bus.busy         = r_state == WAIT;
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: scoreboard bench for timer_sequencer with a behavioural countdown timer.
// Inputs change 1ns after posedge, the timer model acts 2ns after posedge, checks run after negedge.
`timescale 1ns/1ps
module tb_timer_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   timer_sequencer_if #(.DEPTH(4)) bus();
   timer_sequencer #(.DEPTH(4), .WDOG_CYC(20)) dut (.clk(clk), .rst(rst), .bus(bus));

   int         tests = 0, fails = 0, cyc = 0, rem = 0, ncmp = 0;
   logic       tmr_en = 1'b1, tmr_force = 1'b0;
   logic [3:0] exp_q[$];
   int         iss_cyc[$];
   logic [3:0] iss_val[$];

   // timer: done is high for the cycle ending L+2 edges after the issue edge
   assign bus.tmr_done = tmr_force | (tmr_en && rem == 1);

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      if (rst) rem = 0;
      else begin
         if (rem > 0) rem = rem - 1;
         if (bus.tmr_start) rem = int'(bus.tmr_load_val) + 3;
      end
   end

   always @(negedge clk) begin
      logic [3:0] e;
      if (!rst) begin
         if (bus.req_valid && bus.req_ready) exp_q.push_back(bus.req_val);
         if (bus.tmr_start) begin
            iss_cyc.push_back(cyc);
            iss_val.push_back(bus.tmr_load_val);
         end
         if (bus.cmp_pulse) begin
            ncmp++;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL scoreboard: cmp_val=%0d reported with no command outstanding", bus.cmp_val);
            end else begin
               e = exp_q.pop_front();
               if (bus.cmp_val !== e) begin
                  fails++;
                  $display("FAIL scoreboard: cmp_val=%0d expected %0d", bus.cmp_val, e);
               end
            end
         end
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask
   task automatic sample(); @(negedge clk); #1; endtask

   task automatic push(input logic [3:0] v);
      bus.req_valid = 1'b1;
      bus.req_val   = v;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_cmps(input int target);
      for (int i = 0; i < 200 && ncmp < target; i++) sample();
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0;
      bus.req_val   = 4'd0;
      bus.hold      = 1'b0;
      repeat (2) tick();
      sample();
      tests++;
      if ({bus.tmr_start, bus.tmr_load_val, bus.cmp_pulse, bus.cmp_val, bus.level, bus.busy, bus.err, bus.req_ready}
          !== {1'b0, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL reset_outputs: start=%b load=%0d cmp=%b cval=%0d level=%0d busy=%b err=%b ready=%b",
                  bus.tmr_start, bus.tmr_load_val, bus.cmp_pulse, bus.cmp_val, bus.level, bus.busy, bus.err, bus.req_ready);
      end
      tick();
      rst = 1'b0;
      sample();
      tests++;
      if (bus.req_ready !== 1'b1 || bus.level !== 3'd0 || bus.tmr_start !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: ready=%b level=%0d start=%b, want 1 0 0", bus.req_ready, bus.level, bus.tmr_start);
      end
   endtask

   task automatic test_single();
      int n, base;
      base = ncmp;
      tick();
      iss_cyc.delete();
      iss_val.delete();
      push(4'd3);
      sample();
      tests++;
      if ({bus.tmr_start, bus.tmr_load_val, bus.level} !== {1'b1, 4'd3, 3'd1}) begin
         fails++;
         $display("FAIL single_issue: start=%b load=%0d level=%0d, want 1 3 1", bus.tmr_start, bus.tmr_load_val, bus.level);
      end
      tick();
      sample();
      tests++;
      if ({bus.busy, bus.tmr_start, bus.level} !== {1'b1, 1'b0, 3'd0}) begin
         fails++;
         $display("FAIL single_wait: busy=%b start=%b level=%0d, want 1 0 0", bus.busy, bus.tmr_start, bus.level);
      end
      n = 0;
      while (bus.tmr_done !== 1'b1 && n < 30) begin
         tick();
         sample();
         n++;
      end
      tests++;
      if (iss_cyc.size() != 1 || cyc - iss_cyc[0] != 5) begin
         fails++;
         $display("FAIL single_done_latency: issues=%0d latency=%0d, want 1 5", iss_cyc.size(), cyc - iss_cyc[0]);
      end
      tick();
      sample();
      tests++;
      if ({bus.cmp_pulse, bus.cmp_val, bus.level, bus.busy} !== {1'b1, 4'd3, 3'd0, 1'b0}) begin
         fails++;
         $display("FAIL single_cmp: cmp=%b val=%0d level=%0d busy=%b, want 1 3 0 0", bus.cmp_pulse, bus.cmp_val, bus.level, bus.busy);
      end
      tick();
      sample();
      tests++;
      if (bus.cmp_pulse !== 1'b0 || ncmp != base + 1) begin
         fails++;
         $display("FAIL single_cmp_width: cmp=%b completions=%0d, want 0 %0d", bus.cmp_pulse, ncmp - base, 1);
      end
   endtask

   task automatic test_idle_done();
      int base;
      base = ncmp;
      tick();
      tmr_force = 1'b1;
      tick();
      tmr_force = 1'b0;
      sample();
      tick();
      sample();
      tests++;
      if (ncmp != base || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL idle_done_ignored: completions=%0d busy=%b, want 0 0", ncmp - base, bus.busy);
      end
   endtask

   task automatic test_fill_back_to_back();
      logic [3:0] vals[4] = '{4'd5, 4'd0, 4'd15, 4'd2};
      int gaps[3] = '{8, 3, 18};
      int base;
      base = ncmp;
      tick();
      bus.hold = 1'b1;
      iss_cyc.delete();
      iss_val.delete();
      for (int i = 0; i < 4; i++) push(vals[i]);
      bus.req_valid = 1'b1;
      bus.req_val   = 4'd9;
      sample();
      tests++;
      if ({bus.level, bus.req_ready, bus.tmr_start} !== {3'd4, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL fill_full: level=%0d ready=%b start=%b, want 4 0 0", bus.level, bus.req_ready, bus.tmr_start);
      end
      tick();
      bus.req_valid = 1'b0;
      sample();
      tests++;
      if (bus.level !== 3'd4 || exp_q.size() != 4) begin
         fails++;
         $display("FAIL fill_refused: level=%0d queued=%0d, want 4 4", bus.level, exp_q.size());
      end
      tick();
      bus.hold = 1'b0;
      wait_cmps(base + 4);
      tests++;
      if (ncmp != base + 4 || iss_cyc.size() != 4) begin
         fails++;
         $display("FAIL fill_count: completions=%0d issues=%0d, want 4 4", ncmp - base, iss_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (iss_val[i] !== vals[i]) begin
               fails++;
               $display("FAIL fill_order[%0d]: load=%0d want %0d", i, iss_val[i], vals[i]);
            end
         end
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (iss_cyc[i+1] - iss_cyc[i] != gaps[i]) begin
               fails++;
               $display("FAIL fill_gap[%0d]: gap=%0d want %0d", i, iss_cyc[i+1] - iss_cyc[i], gaps[i]);
            end
         end
      end
   endtask

   task automatic test_hold_mid();
      int base;
      base = ncmp;
      tick();
      iss_cyc.delete();
      iss_val.delete();
      push(4'd4);
      push(4'd6);
      bus.hold = 1'b1;
      wait_cmps(base + 1);
      repeat (10) begin
         tick();
         sample();
      end
      tests++;
      if (ncmp != base + 1 || iss_cyc.size() != 1 || bus.level !== 3'd1 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL hold_mid: completions=%0d issues=%0d level=%0d busy=%b, want 1 1 1 0",
                  ncmp - base, iss_cyc.size(), bus.level, bus.busy);
      end
      tick();
      bus.hold = 1'b0;
      wait_cmps(base + 2);
      tests++;
      if (ncmp != base + 2 || iss_val.size() != 2 || iss_val[1] !== 4'd6) begin
         fails++;
         $display("FAIL hold_release: completions=%0d issues=%0d load=%0d, want 2 2 6", ncmp - base, iss_val.size(), iss_val[1]);
      end
   endtask

   task automatic test_simul_push_issue();
      int base;
      base = ncmp;
      tick();
      bus.hold = 1'b1;
      push(4'd1);
      push(4'd2);
      bus.hold      = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_val   = 4'd3;
      sample();
      tests++;
      if ({bus.level, bus.tmr_start, bus.req_ready, bus.tmr_load_val} !== {3'd2, 1'b1, 1'b1, 4'd1}) begin
         fails++;
         $display("FAIL simul_pre: level=%0d start=%b ready=%b load=%0d, want 2 1 1 1",
                  bus.level, bus.tmr_start, bus.req_ready, bus.tmr_load_val);
      end
      tick();
      bus.req_valid = 1'b0;
      sample();
      tests++;
      if (bus.level !== 3'd2 || bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL simul_level: level=%0d busy=%b, want 2 1", bus.level, bus.busy);
      end
      wait_cmps(base + 3);
      tests++;
      if (ncmp != base + 3) begin
         fails++;
         $display("FAIL simul_count: completions=%0d want 3", ncmp - base);
      end
   endtask

`ifdef TSEQ_WDOG_EN
   task automatic test_watchdog();
      int n, base;
      base = ncmp;
      tick();
      tmr_en = 1'b0;
      push(4'd7);
      push(4'd3);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         sample();
         if (bus.busy) n++;
         else if (n > 0) break;
         tick();
      end
      tests++;
      if (n != 20 || bus.err !== 1'b1 || ncmp != base || {bus.tmr_start, bus.tmr_load_val} !== {1'b1, 4'd3}) begin
         fails++;
         $display("FAIL wdog_timeout: wait_cycles=%0d err=%b completions=%0d start=%b load=%0d, want 20 1 0 1 3",
                  n, bus.err, ncmp - base, bus.tmr_start, bus.tmr_load_val);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      tmr_en = 1'b1;
      wait_cmps(base + 1);
      tests++;
      if (ncmp != base + 1 || bus.err !== 1'b1) begin
         fails++;
         $display("FAIL wdog_recover: completions=%0d err=%b, want 1 1", ncmp - base, bus.err);
      end
   endtask
`endif

   task automatic test_reset_mid();
      int base;
      tick();
      bus.hold = 1'b1;
      push(4'd8);
      push(4'd9);
      push(4'd10);
      bus.hold = 1'b0;
      repeat (4) tick();
      sample();
      tests++;
      if (bus.busy !== 1'b1 || bus.level !== 3'd2) begin
         fails++;
         $display("FAIL reset_mid_setup: busy=%b level=%0d, want 1 2", bus.busy, bus.level);
      end
      tick();
      rst = 1'b1;
      #1;
      tests++;
      if ({bus.tmr_start, bus.tmr_load_val, bus.cmp_pulse, bus.cmp_val, bus.level, bus.busy, bus.err, bus.req_ready}
          !== {1'b0, 4'd0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL reset_mid_outputs: start=%b load=%0d cmp=%b cval=%0d level=%0d busy=%b err=%b ready=%b",
                  bus.tmr_start, bus.tmr_load_val, bus.cmp_pulse, bus.cmp_val, bus.level, bus.busy, bus.err, bus.req_ready);
      end
      exp_q.delete();
      iss_cyc.delete();
      base = ncmp;
      tick();
      rst = 1'b0;
      repeat (30) begin
         tick();
         sample();
      end
      tests++;
      if (ncmp != base || iss_cyc.size() != 0 || bus.level !== 3'd0 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_after: completions=%0d issues=%0d level=%0d busy=%b, want 0 0 0 0",
                  ncmp - base, iss_cyc.size(), bus.level, bus.busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_idle_done();
      test_fill_back_to_back();
      test_hold_mid();
      test_simul_push_issue();
`ifdef TSEQ_WDOG_EN
      test_watchdog();
`else
      tests++;
      if (bus.err !== 1'b0) begin
         fails++;
         $display("FAIL err_tied: err=%b want 0", bus.err);
      end
`endif
      test_reset_mid();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d commands never completed, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
